// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller: absorbs the FIFO's 1-cycle read latency into a 2-entry valid/ready buffer.
// Latency 2 cycles from fifo_ren to m_valid; fifo_ren is withheld whenever a returning word could not be buffered.
module fifo_stream_reader #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_ren,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]        occ;
    logic              inflight;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              pop;
    logic [1:0]        held;
    logic [1:0]        occ_after_pop;

    assign m_valid       = (occ != 2'd0);
    assign m_data        = head;
    assign pop           = m_valid & m_ready;
    assign busy          = m_valid | inflight;
    assign held          = occ + {1'b0, inflight};
    assign occ_after_pop = occ - {1'b0, pop};

    // A read is only issued if its data has a guaranteed slot when it returns.
    assign fifo_ren = ~rst & en & ~fifo_empty &
                      ((held <= 2'd1) | ((held == 2'd2) & pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            word_cnt <= '0;
        end else begin
            inflight <= fifo_ren;
            occ      <= occ_after_pop + {1'b0, inflight};
            if (pop) begin
                word_cnt <= word_cnt + CNT_ONE;
            end
            if (pop && occ == 2'd2) begin
                head <= tail;
            end
            // Returning word lands in whichever slot is the first free one after this cycle's pop.
            if (inflight) begin
                if (occ_after_pop == 2'd0) begin
                    head <= fifo_dout;
                end else begin
                    tail <= fifo_dout;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a behavioural FIFO (1-cycle read latency) and an output recorder.
module tb_fifo_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        m_ready = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] fifo_dout = 16'h0;
    logic        fifo_empty;
    logic        fifo_ren, m_valid, busy;
    logic [15:0] m_data, word_cnt;
    logic        fifo_ren4, m_valid4, busy4;
    logic [15:0] m_data4;
    logic [3:0]  word_cnt4;

    logic [15:0] mem [0:4095];
    logic [15:0] outw [0:4095];
    int wr_ptr = 0, rd_ptr = 0, rd_cnt = 0, out_cnt = 0, held = 0, viol = 0;
    int checks = 0, failures = 0;
    int exp_base = 0, out_base = 0;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        ren;
        logic        vld;
        logic [15:0] dat;
        logic        bsy;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;
    assign fifo_empty = (rd_ptr == wr_ptr);

    fifo_stream_reader #(.DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_ren(fifo_ren), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .word_cnt(word_cnt)
    );

    fifo_stream_reader #(.DATA_W(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_ren(fifo_ren4), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
        .busy(busy4), .word_cnt(word_cnt4)
    );

    // FIFO model and output recorder.
    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_ren && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr[11:0]];
            rd_ptr    <= rd_ptr + 1;
            rd_cnt    <= rd_cnt + 1;
        end
        if (!rst && m_valid && m_ready) begin
            outw[out_cnt[11:0]] <= m_data;
            out_cnt <= out_cnt + 1;
        end
    end

    // Words owned by the reader (buffered or in flight); a read with two owned and no pop is unsafe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= 0;
        end else begin
            if (fifo_ren && held >= 2 && !(m_valid && m_ready)) viol <= viol + 1;
            held <= held + ((fifo_ren && !fifo_empty) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        mem[wr_ptr[11:0]] = d;
        wr_ptr++;
    endtask

    task automatic mark();
        exp_base = wr_ptr;
        out_base = out_cnt;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int c = 0; c < budget && (out_cnt - out_base) < n; c++) cyc();
    endtask

    task automatic check_stream(input string name, input int n);
        int nbad;
        nbad = 0;
        check({name, " count"}, out_cnt - out_base, n);
        for (int i = 0; i < n; i++)
            if (outw[(out_base + i) % 4096] !== mem[(exp_base + i) % 4096]) nbad++;
        check({name, " data mismatches"}, nbad, 0);
    endtask

    initial begin
        int r0;
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 16'd2};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'd3};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 16'd4};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'd5};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, 1'b1, 16'd6};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b1, 16'd7};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0008, 1'b0, 16'd8};

        // Reset state.
        #1;
        check("reset m_valid", m_valid, 0);
        check("reset busy", busy, 0);
        check("reset word_cnt", word_cnt, 0);
        check("reset m_data", m_data, 0);
        check("reset fifo_ren", fifo_ren, 0);
        check("reset fifo_ren cnt4", fifo_ren4, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Reset mid-stream with words buffered and in flight.
        for (int i = 0; i < 8; i++) push(16'h00A0 + 16'(i));
        en = 1'b1; m_ready = 1'b1;
        repeat (4) cyc();
        m_ready = 1'b0;
        repeat (2) cyc();
        check("t1 buffered before reset", m_valid, 1);
        rst = 1'b1;
        #1;
        check("t1 m_valid in reset", m_valid, 0);
        check("t1 busy in reset", busy, 0);
        check("t1 word_cnt in reset", word_cnt, 0);
        check("t1 fifo_ren in reset", fifo_ren, 0);
        en = 1'b0;
        do_flush();
        check("t1 fifo_ren still in reset", fifo_ren, 0);
        rst = 1'b0;
        cyc();

        // Full-throughput stream: latency and ordering, cycle by cycle.
        mark();
        for (int i = 1; i <= 8; i++) push(16'(i));
        for (int k = 0; k < 11; k++) begin
            en = tbl[k].en;
            m_ready = tbl[k].rdy;
            #1;
            check($sformatf("t2 cycle %0d {ren,vld,dat,busy,cnt}", k),
                  {fifo_ren, m_valid, m_data, busy, word_cnt},
                  {tbl[k].ren, tbl[k].vld, tbl[k].dat, tbl[k].bsy, tbl[k].cnt});
            cyc();
        end
        check_stream("t2", 8);

        // Backpressure with 4 words: only two reads until the consumer is ready.
        en = 1'b0; m_ready = 1'b0;
        mark();
        for (int i = 1; i <= 4; i++) push(16'(i));
        r0 = rd_cnt;
        en = 1'b1;
        repeat (6) cyc();
        check("t3 reads while stalled", rd_cnt - r0, 2);
        check("t3 fifo_ren while full", fifo_ren, 0);
        check("t3 m_valid held", m_valid, 1);
        check("t3 m_data held", m_data, 16'h0001);
        m_ready = 1'b1;
        wait_out(4, 40);
        check_stream("t3", 4);
        en = 1'b0;
        cyc();

        // Random backpressure over 1000 words.
        mark();
        for (int i = 0; i < 1000; i++) push(16'($urandom));
        en = 1'b1;
        for (int c = 0; c < 6000 && (out_cnt - out_base) < 1000; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        m_ready = 1'b1; en = 1'b0;
        repeat (3) cyc();
        check_stream("t4", 1000);
        check("t4 unsafe fifo_ren count", viol, 0);

        // en dropped one cycle after the first read.
        mark();
        for (int i = 0; i < 4; i++) push(16'h0051 + 16'(i));
        r0 = rd_cnt;
        en = 1'b1;
        #1;
        check("t5 first fifo_ren", fifo_ren, 1);
        cyc();
        en = 1'b0;
        #1;
        check("t5 fifo_ren after en drop", fifo_ren, 0);
        repeat (5) cyc();
        check("t5 reads issued", rd_cnt - r0, 1);
        check("t5 busy after drain", busy, 0);
        check("t5 FIFO words left", wr_ptr - rd_ptr, 3);
        check_stream("t5", 1);
        do_flush();

        // Counter wrap on the 4-bit instance.
        rst = 1'b1;
        #1;
        do_flush();
        rst = 1'b0;
        mark();
        for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
        en = 1'b1; m_ready = 1'b1;
        wait_out(17, 100);
        en = 1'b0;
        repeat (2) cyc();
        check("t6 word_cnt CNT_W=4 wrap", word_cnt4, 4'd1);
        check("t6 word_cnt CNT_W=16", word_cnt, 16'd17);
        check("t6 CNT_W=4 idle", {busy4, m_valid4}, 2'b00);
        check("t6 CNT_W=4 last data", m_data4, 16'h0110);
        check_stream("t6", 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
